adc_trig_capture: RTL and testbench
===================================

// Module: adc_trig_capture
// PURPOSE
//  Capture engine on the ADC side of the scope. It is the reader that pairs with the DDS/DAC writer.
//  It takes 8-bit ADC samples on a strobe and keeps a circular pre-trigger history.
//  It fires on a level/edge trigger, or on an auto-trigger timeout, and fills the post-trigger window.
//  It then streams the whole frame, oldest sample first, to the display/waveform path over valid/ready.
// PARAMETERS
//  DATA_W   8     sample width
//  ADDR_W   10    buffer address width; DEPTH = 2**ADDR_W samples per frame
//  AUTO_TO  65535 samples to wait for a trigger before forcing one; 0 disables auto-trigger
// PORTS
//  sys_clk      in   1       single clock; all logic runs on its rising edge
//  sys_rst_n    in   1       asynchronous active-low reset
//  arm          in   1       1-cycle pulse; starts a capture; honoured only in IDLE
//  ad_strobe    in   1       1-cycle sample-valid strobe (ADC sample rate <= sys_clk)
//  ad_data      in   DATA_W  ADC sample; used only when ad_strobe=1
//  trig_level   in   DATA_W  trigger threshold (unsigned)
//  trig_edge    in   1       0 = rising edge, 1 = falling edge
//  pretrig      in   ADDR_W  samples kept before the trigger sample
//  rd_valid     out  1       frame sample available
//  rd_ready     in   1       consumer accepts the sample
//  rd_data      out  DATA_W  frame sample
//  rd_last      out  1       marks sample DEPTH-1 of the frame
//  busy         out  1       high in every state except IDLE
//  triggered    out  1       set when the trigger fires; cleared on arm
//  auto_trig    out  1       set when the frame was forced by timeout; cleared on arm
// BEHAVIOUR
//  Reset: state=IDLE. rd_valid, rd_last, busy, triggered and auto_trig are 0. rd_data=0.
//    All pointers and counters are 0. Reset is honoured in any state and abandons the frame.
//  Latched on arm: trig_level, trig_edge and pretrig. Later changes have no effect until the next arm.
//    pretrig is clamped to DEPTH-1.
//  A strobe in the same cycle as arm is not captured. Capture starts with the next strobe.
//  Every strobe in PREFILL, WAIT_TRIG or POSTFILL writes ad_data to buf[wr_ptr].
//    wr_ptr then increments modulo DEPTH (wraps naturally).
//  PREFILL: count strobes. Move to WAIT_TRIG after pretrig samples.
//    With pretrig=0, move to WAIT_TRIG in the cycle after arm.
//  WAIT_TRIG: prev holds the previous captured sample; prev_vld=0 right after arm.
//    Rising trigger: prev_vld && prev < level && cur >= level.
//    Falling trigger: prev_vld && prev > level && cur <= level.
//    On the trigger strobe, cur is written and trig_addr = its address. Set triggered.
//    Go to POSTFILL, needing DEPTH-pretrig-1 more samples.
//    With AUTO_TO != 0 and AUTO_TO strobes in WAIT_TRIG without a trigger, the AUTO_TO-th strobe is forced as the trigger.
//    A forced trigger sets triggered and auto_trig.
//  While WAIT_TRIG, the history keeps rolling, overwriting the oldest samples.
//    After the trigger, the frame holds exactly pretrig samples before trig_addr.
//  POSTFILL: when the remaining count reaches 0 (possibly immediately), go to READOUT.
//    In READOUT, rd_ptr = trig_addr - pretrig (mod DEPTH).
//  READOUT: strobes are ignored. Buffer read latency is 1 cycle.
//    rd_valid rises at most 2 cycles after entry.
//    rd_data/rd_last hold stable while rd_valid && !rd_ready.
//    On each rd_valid && rd_ready, advance to the next address. A back-to-back ready sustains 1 sample/cycle.
//    rd_last=1 with the DEPTH-th sample. Its handshake returns to IDLE; rd_valid=0 next cycle.
//  arm outside IDLE is ignored (no restart, no flag change).
// TESTING
//  T1 reset mid-POSTFILL -> outputs at reset values immediately; next arm yields a clean frame.
//  T2 ADDR_W=4, pretrig=4, rising, level=0x80.
//     ramp 0x00,0x10,..(step 0x10) -> trigger on 0x80 sample.
//     Readout = 0x40,0x50,0x60,0x70,0x80,.. 16 samples; rd_last on 16th; auto_trig=0.
//  T3 Falling, level=0x80, square wave 0xFF/0x00.
//     Trigger sample = first 0x00 after 0xFF; its frame index = pretrig.
//  T4 AUTO_TO=8, constant 0x20, level=0x80 -> forced trigger on 8th WAIT_TRIG strobe.
//     triggered=1, auto_trig=1; full frame read.
//  T5 pretrig=0 and pretrig=DEPTH-1.
//     First sample after arm never triggers.
//     Trigger lands at frame index 0 / DEPTH-1 respectively.
//  T6 Readout with random rd_ready stalls; arm and strobes during READOUT.
//     Data stable under stall; no loss/duplication; arm ignored; busy=1 until last handshake.

Source files
------------

// File: rtl/adc_trig_capture.sv
`default_nettype none
// =============================================================================
// Module   : adc_trig_capture
// Brief    : ADC-side scope capture: circular pre-trigger history, level/edge or
//            auto-timeout trigger, post-fill, then oldest-first valid/ready readout.
// Revision : 1.0
// =============================================================================
module adc_trig_capture #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 10,
    parameter int AUTO_TO = 65535
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              arm,
    input  logic              ad_strobe,
    input  logic [DATA_W-1:0] ad_data,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_edge,
    input  logic [ADDR_W-1:0] pretrig,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              triggered,
    output logic              auto_trig
);

    localparam int                C_DEPTH    = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] C_ADDR_MAX = '1;
    localparam logic [31:0]       C_AUTO_TO  = 32'(AUTO_TO);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREFILL  = 3'd1,
        S_WAIT     = 3'd2,
        S_POSTFILL = 3'd3,
        S_READOUT  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   level_q, level_d;
    logic                edge_q, edge_d;
    logic [ADDR_W-1:0]   pre_q, pre_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [31:0]         auto_cnt_q, auto_cnt_d;
    logic [DATA_W-1:0]   prev_q, prev_d;
    logic                prev_vld_q, prev_vld_d;
    logic                rd_valid_q, rd_valid_d;
    logic                trig_q, trig_d;
    logic                auto_q, auto_d;
    logic [DATA_W-1:0]   mem_rd_q;
    logic [DATA_W-1:0]   mem_q [C_DEPTH];

    logic                w_we;
    logic [ADDR_W-1:0]   w_raddr;
    logic                w_fire;
    logic                w_hit;
    logic                w_force;
    logic [ADDR_W-1:0]   w_cnt_inc;

    assign w_fire    = rd_valid_q && rd_ready;
    assign w_cnt_inc = cnt_q + 1'b1;
    assign w_hit     = prev_vld_q && (edge_q ? ((prev_q > level_q) && (ad_data <= level_q))
                                             : ((prev_q < level_q) && (ad_data >= level_q)));
    assign w_force   = (C_AUTO_TO != 32'd0) && ((auto_cnt_q + 32'd1) == C_AUTO_TO);

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        edge_d     = edge_q;
        pre_d      = pre_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        auto_cnt_d = auto_cnt_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        rd_valid_d = rd_valid_q;
        trig_d     = trig_q;
        auto_d     = auto_q;
        w_we       = 1'b0;
        w_raddr    = rd_ptr_q;

        unique case (state_q)
            S_IDLE: begin
                if (arm) begin
                    // The port width already bounds pretrig to DEPTH-1.
                    level_d    = trig_level;
                    edge_d     = trig_edge;
                    pre_d      = pretrig;
                    cnt_d      = '0;
                    auto_cnt_d = '0;
                    prev_vld_d = 1'b0;
                    trig_d     = 1'b0;
                    auto_d     = 1'b0;
                    state_d    = (pretrig == '0) ? S_WAIT : S_PREFILL;
                end
            end
            S_PREFILL: begin
                if (ad_strobe) begin
                    w_we       = 1'b1;
                    wr_ptr_d   = wr_ptr_q + 1'b1;
                    prev_d     = ad_data;
                    prev_vld_d = 1'b1;
                    cnt_d      = w_cnt_inc;
                    if (w_cnt_inc == pre_q) begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (ad_strobe) begin
                    w_we       = 1'b1;
                    wr_ptr_d   = wr_ptr_q + 1'b1;
                    prev_d     = ad_data;
                    prev_vld_d = 1'b1;
                    auto_cnt_d = auto_cnt_q + 32'd1;
                    if (w_hit || w_force) begin
                        trig_d   = 1'b1;
                        auto_d   = !w_hit;
                        rd_ptr_d = wr_ptr_q - pre_q;
                        cnt_d    = C_ADDR_MAX - pre_q;
                        state_d  = S_POSTFILL;
                    end
                end
            end
            S_POSTFILL: begin
                // A full history must not be overwritten once the window is complete.
                if (cnt_q == '0) begin
                    state_d = S_READOUT;
                end else if (ad_strobe) begin
                    w_we     = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    cnt_d    = cnt_q - 1'b1;
                end
            end
            S_READOUT: begin
                if (!rd_valid_q) begin
                    rd_valid_d = 1'b1;
                end else if (w_fire) begin
                    w_raddr  = rd_ptr_q + 1'b1;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    cnt_d    = w_cnt_inc;
                    if (cnt_q == C_ADDR_MAX) begin
                        rd_valid_d = 1'b0;
                        state_d    = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            level_q    <= '0;
            edge_q     <= 1'b0;
            pre_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            auto_cnt_q <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            rd_valid_q <= 1'b0;
            trig_q     <= 1'b0;
            auto_q     <= 1'b0;
            mem_rd_q   <= '0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            edge_q     <= edge_d;
            pre_q      <= pre_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            auto_cnt_q <= auto_cnt_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            rd_valid_q <= rd_valid_d;
            trig_q     <= trig_d;
            auto_q     <= auto_d;
            // Re-reading the current address while stalled keeps rd_data stable.
            if (state_q == S_READOUT) begin
                mem_rd_q <= mem_q[w_raddr];
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_we) begin
            mem_q[wr_ptr_q] <= ad_data;
        end
    end

    assign rd_valid  = rd_valid_q;
    assign rd_data   = mem_rd_q;
    assign rd_last   = rd_valid_q && (cnt_q == C_ADDR_MAX);
    assign busy      = (state_q != S_IDLE);
    assign triggered = trig_q;
    assign auto_trig = auto_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_trig_capture.sv
`default_nettype none
// =============================================================================
// Module   : tb_adc_trig_capture
// Brief    : Directed self-checking bench; expected frames come from a sample-list model.
// Revision : 1.0
// =============================================================================
module tb_adc_trig_capture;

    localparam int DEPTH = 16;
    localparam int ATO   = 8;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       arm        = 1'b0;
    logic       ad_strobe  = 1'b0;
    logic [7:0] ad_data    = 8'h00;
    logic [7:0] trig_level = 8'h00;
    logic       trig_edge  = 1'b0;
    logic [3:0] pretrig    = 4'h0;
    logic       rd_ready   = 1'b0;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_last;
    logic       busy;
    logic       triggered;
    logic       auto_trig;

    int n_chk      = 0;
    int n_pass     = 0;
    int exp_frame[DEPTH];
    int got[DEPTH];
    int frame_seq  = 0;
    int seen_seq   = 0;
    int done_seq   = 0;
    int rd_idx     = 0;
    int ready_mode = 0;

    always #5 clk = ~clk;

    adc_trig_capture #(
        .DATA_W  (8),
        .ADDR_W  (4),
        .AUTO_TO (ATO)
    ) u_dut (
        .sys_clk    (clk),
        .sys_rst_n  (rst_n),
        .arm        (arm),
        .ad_strobe  (ad_strobe),
        .ad_data    (ad_data),
        .trig_level (trig_level),
        .trig_edge  (trig_edge),
        .pretrig    (pretrig),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .rd_last    (rd_last),
        .busy       (busy),
        .triggered  (triggered),
        .auto_trig  (auto_trig)
    );

    task automatic check(input string nm, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame from the list of samples captured after arm: first trigger at or after
    // index p, then DEPTH samples starting p before it.
    function automatic void model_frame(input int s[$], input int p, input bit fall,
                                        input int lv, output int t, output bit forced,
                                        output bit ok);
        bit hit;
        t = -1; forced = 1'b0; ok = 1'b0;
        for (int j = p; j < s.size(); j++) begin
            hit = 1'b0;
            if (j >= 1)
                hit = fall ? (s[j-1] > lv && s[j] <= lv) : (s[j-1] < lv && s[j] >= lv);
            if (hit || (j - p + 1 == ATO)) begin
                t = j; forced = !hit;
                break;
            end
        end
        if (t >= 0 && t - p + DEPTH <= s.size()) begin
            ok = 1'b1;
            for (int k = 0; k < DEPTH; k++) exp_frame[k] = s[t - p + k];
        end
    endfunction

    task automatic do_arm(input int p, input bit fall, input int lv);
        pretrig    = 4'(p);
        trig_edge  = fall;
        trig_level = 8'(lv);
        arm        = 1'b1;
        ad_strobe  = 1'b1;
        ad_data    = 8'hEE;
        tick();
        arm        = 1'b0;
        ad_strobe  = 1'b0;
        pretrig    = 4'($urandom);
        trig_edge  = 1'($urandom);
        trig_level = 8'($urandom);
    endtask

    task automatic send(input int v, input int gap);
        ad_strobe = 1'b1;
        ad_data   = 8'(v);
        tick();
        ad_strobe = 1'b0;
        ad_data   = 8'($urandom);
        repeat (gap) tick();
    endtask

    task automatic run_frame(input string tn, input int s[$], input int p, input bit fall,
                             input int lv, input int mode, input bit arm_in_readout,
                             output int t);
        bit forced, ok;
        model_frame(s, p, fall, lv, t, forced, ok);
        check({tn, " model frame fits stimulus"}, int'(ok), 1);
        frame_seq++;
        ready_mode = mode;
        do_arm(p, fall, lv);
        check({tn, " busy after arm"}, int'(busy), 1);
        check({tn, " triggered cleared by arm"}, int'(triggered), 0);
        foreach (s[i]) send(s[i], i % 3);
        if (arm_in_readout) begin
            for (int c = 0; c < 500 && rd_idx < 4; c++) tick();
            arm = 1'b1; ad_strobe = 1'b1; ad_data = 8'h00; pretrig = 4'd0;
            tick();
            arm = 1'b0; ad_strobe = 1'b0;
            check({tn, " triggered kept on ignored arm"}, int'(triggered), 1);
            check({tn, " auto_trig kept on ignored arm"}, int'(auto_trig), int'(forced));
            check({tn, " busy kept on ignored arm"}, int'(busy), 1);
        end
        for (int c = 0; c < 2000 && done_seq != frame_seq; c++) tick();
        check({tn, " frame fully read"}, done_seq, frame_seq);
        check({tn, " triggered"}, int'(triggered), 1);
        check({tn, " auto_trig"}, int'(auto_trig), int'(forced));
    endtask

    initial begin
        int s[$];
        int t;

        fork
            forever begin
                @(posedge clk);
                #1;
                rd_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            forever begin
                @(negedge clk);
                if (seen_seq != frame_seq) begin
                    seen_seq = frame_seq;
                    rd_idx   = 0;
                end
                if (rst_n && rd_valid) begin
                    if (rd_idx >= DEPTH) begin
                        check("rd_valid beyond frame", int'(rd_valid), 0);
                    end else begin
                        check($sformatf("rd_data[%0d]", rd_idx), int'(rd_data), exp_frame[rd_idx]);
                        check($sformatf("rd_last[%0d]", rd_idx), int'(rd_last), (rd_idx == DEPTH-1) ? 1 : 0);
                        check("busy in readout", int'(busy), 1);
                        if (rd_ready) begin
                            got[rd_idx] = int'(rd_data);
                            rd_idx++;
                        end
                    end
                end else if (rst_n && rd_idx == DEPTH && done_seq != seen_seq) begin
                    check("busy after last handshake", int'(busy), 0);
                    done_seq = seen_seq;
                end
            end
            begin
                #2000000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        rst_n = 1'b0;
        repeat (3) tick();
        check("reset busy", int'(busy), 0);
        check("reset rd_valid", int'(rd_valid), 0);
        check("reset rd_last", int'(rd_last), 0);
        check("reset triggered", int'(triggered), 0);
        check("reset auto_trig", int'(auto_trig), 0);
        check("reset rd_data", int'(rd_data), 0);
        rst_n = 1'b1;
        tick();

        // T1: reset while post-filling
        do_arm(4, 1'b0, 8'h80);
        for (int i = 0; i < 12; i++) send((i * 16) & 255, 1);
        check("T1 triggered before reset", int'(triggered), 1);
        check("T1 busy in postfill", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("T1 busy after reset", int'(busy), 0);
        check("T1 triggered after reset", int'(triggered), 0);
        check("T1 auto_trig after reset", int'(auto_trig), 0);
        check("T1 rd_valid after reset", int'(rd_valid), 0);
        check("T1 rd_last after reset", int'(rd_last), 0);
        check("T1 rd_data after reset", int'(rd_data), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // T2: rising ramp, pretrig 4
        s = {};
        for (int i = 0; i < 20; i++) s.push_back((i * 16) & 255);
        run_frame("T2", s, 4, 1'b0, 8'h80, 0, 1'b0, t);
        check("T2 model trigger index", t, 8);
        check("T2 frame[0]", got[0], 8'h40);
        check("T2 frame[3]", got[3], 8'h70);
        check("T2 frame[4]", got[4], 8'h80);
        check("T2 frame[15]", got[15], 8'h30);

        // T3: falling square wave
        s = {};
        for (int i = 0; i < 24; i++) s.push_back((i % 2 == 0) ? 8'hFF : 8'h00);
        run_frame("T3", s, 5, 1'b1, 8'h80, 0, 1'b0, t);
        check("T3 model trigger index", t, 5);
        check("T3 frame[pretrig]", got[5], 8'h00);
        check("T3 frame[pretrig-1]", got[4], 8'hFF);

        // T4: constant below level forces a trigger
        s = {};
        for (int i = 0; i < 26; i++) s.push_back(8'h20);
        run_frame("T4", s, 4, 1'b0, 8'h80, 0, 1'b0, t);
        check("T4 model forced index", t, 11);
        check("T4 frame[0]", got[0], 8'h20);

        // T4b: slow ramp below level exposes the forced sample position
        s = {};
        for (int i = 0; i < 26; i++) s.push_back(i * 4);
        run_frame("T4b", s, 4, 1'b0, 8'h80, 0, 1'b0, t);
        check("T4b model forced index", t, 11);
        check("T4b frame[0]", got[0], 8'h1C);
        check("T4b frame[4]", got[4], 8'h2C);

        // T5a: pretrig 0, first sample above level must not trigger
        s = {};
        s.push_back(8'h90);
        for (int j = 1; j < 20; j++) s.push_back((j % 2 == 1) ? (8'h10 + j) : (8'h90 + j));
        run_frame("T5a", s, 0, 1'b0, 8'h80, 0, 1'b0, t);
        check("T5a model trigger index", t, 2);
        check("T5a frame[0]", got[0], 8'h92);
        check("T5a frame[1]", got[1], 8'h13);

        // T5b: pretrig DEPTH-1, trailing strobes must be dropped
        s = {};
        for (int i = 0; i < 15; i++) s.push_back(i * 4);
        s.push_back(8'hC0);
        s.push_back(8'h99);
        s.push_back(8'h98);
        run_frame("T5b", s, 15, 1'b0, 8'h80, 0, 1'b0, t);
        check("T5b model trigger index", t, 15);
        check("T5b frame[0]", got[0], 8'h00);
        check("T5b frame[14]", got[14], 8'h38);
        check("T5b frame[15]", got[15], 8'hC0);

        // T6: random stalls, arm and strobes during readout
        s = {};
        for (int i = 0; i < 30; i++) s.push_back((i * 29 + 7) & 255);
        run_frame("T6", s, 6, 1'b0, 8'h40, 1, 1'b1, t);

        repeat (4) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
